// File: rtl/reg_mem_arb_pkg.sv
// reg_mem_arb_pkg: shared FSM state enum and default sizes for the reg_mem arbiter
package reg_mem_arb_pkg;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int ADDR_BITS_DEF  = 3;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
endpackage

// File: rtl/reg_mem_arb_rr_pick2.sv
// rr_pick2: two-way round-robin pick; ptr = 1 gives requester 1 the tie
module rr_pick2
  import reg_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  // a lone requester always wins; a tie goes to the side ptr favours
  always_comb begin
    gnt[0] = req[0] & (~req[1] | ~ptr);
    gnt[1] = req[1] & (~req[0] | ptr);
  end
endmodule

// File: rtl/reg_mem_arb.sv
// reg_mem_arb: two-requester round-robin arbiter for a shared reg_mem; lock support under REG_MEM_ARB_LOCK_EN
module reg_mem_arb
  import reg_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  lock0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]            req, pick;
  logic                  tie_ptr;
`ifdef REG_MEM_ARB_LOCK_EN
  logic                  lk_q, lk_d;
  logic                  held, own_lock;
  // a locked owner masks the other requester until it drops its lock
  always_comb begin
    held     = lk_q & (state_q != IDLE);
    own_lock = (state_q == OWN0) ? lock0 : lock1;
    req      = {req1 & ~(held & (state_q == OWN0)), req0 & ~(held & (state_q == OWN1))};
  end
`else
  logic                  unused_lock;
  assign unused_lock = lock0 ^ lock1;
  assign req = {req1, req0};
`endif
  // the last owner favours the other side; in IDLE the remembered pointer decides
  assign tie_ptr = (state_q == OWN0) | ((state_q == IDLE) & ptr_q);
  rr_pick2 u_pick (
    .req (req),
    .ptr (tie_ptr),
    .gnt (pick)
  );
  assign gnt0    = pick[0] & rst_n;
  assign gnt1    = pick[1] & rst_n;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  // route the granted requester onto the reg_mem port, zeros when idle
  always_comb begin
    mem_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    mem_wen   = (gnt0 & we0) | (gnt1 & we1);
  end
  // next ownership, pointer and read-return values
  always_comb begin
    state_d   = gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
    ptr_d     = (state_q == IDLE) ? ptr_q : (state_q == OWN0);
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
`ifdef REG_MEM_ARB_LOCK_EN
    lk_d      = gnt0 ? lock0 : gnt1 ? lock1 : held & own_lock;
    state_d   = (~gnt0 & ~gnt1 & held & own_lock) ? state_q : state_d;
`endif
  end
  // FSM and read-return registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef REG_MEM_ARB_LOCK_EN
      lk_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifdef REG_MEM_ARB_LOCK_EN
      lk_q      <= lk_d;
`endif
    end
  end
endmodule

// File: tb/tb_reg_mem_arb.sv
// tb_reg_mem_arb: directed and random checks of reg_mem_arb against a transaction-level model
module tb_reg_mem_arb;
  localparam int DW = 4;
  localparam int AW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, mem_addr;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, rdata0, rdata1, mem_wdata, mem_rdata;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_wen;
  logic [DW-1:0] env_mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  int last, lk_own;
  logic ev0, ev1, g0_seen, g1_seen;
  logic [DW-1:0] ed0, ed1;
  int n_chk = 0, n_pass = 0;

  reg_mem_arb #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // the reg_mem that sits beside the arbiter: combinational read, write at the edge
  assign mem_rdata = env_mem[mem_addr];
  always @(posedge clk) if (mem_wen) env_mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0; last = -1; lk_own = -1;
  endtask

  // one clock cycle: drive at posedge+1, check at the falling edge, advance the model
  task automatic cyc(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic l0, input logic l1);
    logic q0, q1, e0, e1, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    q0 = r0; q1 = r1;
`ifdef REG_MEM_ARB_LOCK_EN
    if (lk_own == 0) q1 = 0;
    if (lk_own == 1) q0 = 0;
`endif
    e0 = q0 && (!q1 || last != 0);
    e1 = q1 && !e0;
    ew = (e0 && w0) || (e1 && w1);
    ea = e0 ? a0 : e1 ? a1 : '0;
    ewd = e0 ? d0 : e1 ? d1 : '0;
    #4;
    g0_seen = gnt0; g1_seen = gnt1;
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    chk("mem_wen", mem_wen, ew);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ewd);
    chk("rvalid0", rvalid0, ev0);
    chk("rdata0", rdata0, ed0);
    chk("rvalid1", rvalid1, ev1);
    chk("rdata1", rdata1, ed1);
    ev0 = e0 && !w0;
    ev1 = e1 && !w1;
    if (ev0) ed0 = ref_mem[a0];
    if (ev1) ed1 = ref_mem[a1];
    if (ew) ref_mem[ea] = ewd;
    if (e0) last = 0;
    if (e1) last = 1;
`ifdef REG_MEM_ARB_LOCK_EN
    if (e0) lk_own = l0 ? 0 : -1;
    else if (e1) lk_own = l1 ? 1 : -1;
    else if (!((lk_own == 0 && l0) || (lk_own == 1 && l1))) lk_own = -1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // assert reset away from the edge while a write is requested, release after two edges
  task automatic do_reset();
    req0 = 1; we0 = 1; addr0 = 3'd6; wdata0 = 4'd9; req1 = 1; we1 = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rdata0", rdata0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    req0 = 0; we0 = 0; req1 = 0; we1 = 0;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("init_rvalid0", rvalid0, 0);
    chk("init_rvalid1", rvalid1, 0);
    chk("init_rdata1", rdata1, 0);
    rst_n = 1;
    // write then read back addr 2, right after reset release
    cyc(1, 1, 3'd2, 4'd10, 0, 0, 0, 0, 0, 0);
    chk("w2_gnt0", g0_seen, 1);
    cyc(1, 0, 3'd2, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rd2_data", rdata0, 4'd10);
    // both requesters reading from reset alternate 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 3'(i), 0, 1, 0, 3'(i + 1), 0, 0, 0);
      chk("rr_alt0", g0_seen, (i % 2) == 0);
      chk("rr_alt1", g1_seen, (i % 2) == 1);
    end
    // requester 1 writes, requester 0 reads the same word next cycle
    cyc(0, 0, 0, 0, 1, 1, 3'd5, 4'd7, 0, 0);
    cyc(1, 0, 3'd5, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("xfer_data", rdata0, 4'd7);
    // reset during a granted read of addr 3 discards it
    cyc(1, 1, 3'd3, 4'd12, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    req0 = 1; we0 = 0; addr0 = 3'd3;
    #2;
    chk("pre_rst_gnt0", gnt0, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_gnt0", gnt0, 0);
    chk("mid_rst_rdata0", rdata0, 0);
    @(posedge clk);
    #1;
    req0 = 0;
    rst_n = 1;
    model_reset();
    #3;
    chk("post_rst_rvalid0", rvalid0, 0);
    chk("post_rst_rdata0", rdata0, 0);
    chk("post_rst_wen", mem_wen, 0);
    @(posedge clk);
    #1;
    // all addresses written by alternating requesters, then read back
    for (int i = 0; i < 2**AW; i++) begin
      if (i % 2 == 0) cyc(1, 1, 3'(i), 4'(10 + i), 0, 0, 0, 0, 0, 0);
      else cyc(0, 0, 0, 0, 1, 1, 3'(i), 4'(10 + i), 0, 0);
    end
    for (int i = 0; i < 2**AW; i++) begin
      cyc(1, 0, 3'(i), 0, 1, 0, 3'(i), 0, 0, 0);
      chk("no_double", g0_seen & g1_seen, 0);
    end
    idle();
`ifdef REG_MEM_ARB_LOCK_EN
    // requester 0 locks for three grants while requester 1 waits
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      chk("lock_g1", g1_seen, 0);
    end
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("unlock_last_g0", g0_seen, 1);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("unlock_g1", g1_seen, 1);
`endif
    // random traffic, locks included
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
